// File: rtl/boss_pkg.sv
// Shared sizing defaults and flash FSM state type for the boss sprite pipeline.
`timescale 1ns/1ps
package boss_pkg;

  localparam int unsigned SPR_W_DEF        = 64;
  localparam int unsigned SPR_H_DEF        = 64;
  localparam int unsigned ROM_AW_DEF       = 12;
  localparam int unsigned FLASH_FRAMES_DEF = 16;
  localparam logic [3:0]  TRANSP_IDX_DEF   = 4'h0;
  localparam int unsigned FCNT_W           = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

endpackage

// File: rtl/boss_flash_fsm.sv
// Damage-flash controller: counts frames after a hit and produces a
// frame-aligned hide strobe so the blink never tears mid-frame.
`timescale 1ns/1ps
module boss_flash_fsm
  import boss_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = FLASH_FRAMES_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic hit,
  input  logic frame_start,
  output logic hidden,
  output logic flashing
);

  flash_state_t        state, state_nx;
  logic [FCNT_W-1:0]   fcnt, fcnt_nx;
  logic                hidden_nx;

  // State, frame counter and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      fcnt     <= '0;
      hidden   <= 1'b0;
      flashing <= 1'b0;
    end else begin
      state    <= state_nx;
      fcnt     <= fcnt_nx;
      hidden   <= hidden_nx;
      flashing <= (state_nx == FLASH);
    end
  end

  // Next-state logic; a hit always wins over a coincident frame_start.
  always_comb begin
    state_nx  = state;
    fcnt_nx   = fcnt;
    hidden_nx = hidden;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nx = FLASH;
          fcnt_nx  = FCNT_W'(FLASH_FRAMES);
        end
      end
      FLASH: begin
        if (hit) begin
          fcnt_nx = FCNT_W'(FLASH_FRAMES);
        end else if (frame_start) begin
          if (fcnt == FCNT_W'(1)) begin
            state_nx = IDLE;
            fcnt_nx  = '0;
          end else begin
            fcnt_nx = fcnt - FCNT_W'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        fcnt_nx  = '0;
      end
    endcase
    if (frame_start) begin
      hidden_nx = (state_nx == FLASH) && fcnt_nx[1];
    end
  end

endmodule

// File: rtl/boss_sprite_fetch.sv
// Boss sprite fetch stage: box test and ROM addressing, ROM-latency alignment,
// transparency and flash blanking. Optional horizontal mirror under BOSS_HFLIP_EN.
`timescale 1ns/1ps
module boss_sprite_fetch
  import boss_pkg::*;
#(
  parameter int unsigned SPR_W        = SPR_W_DEF,
  parameter int unsigned SPR_H        = SPR_H_DEF,
  parameter int unsigned ROM_AW       = ROM_AW_DEF,
  parameter int unsigned FLASH_FRAMES = FLASH_FRAMES_DEF,
  parameter logic [3:0]  TRANSP_IDX   = TRANSP_IDX_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic [9:0]        boss_x,
  input  logic [9:0]        boss_y,
  input  logic              hit,
`ifdef BOSS_HFLIP_EN
  input  logic              flip,
`endif
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        index,
  output logic              boss_on,
  output logic              flashing
);

  localparam int unsigned XW = $clog2(SPR_W);
  localparam int unsigned YW = $clog2(SPR_H);

  logic [10:0]       rx_c, ry_c;
  logic              in_box_c;
  logic [XW-1:0]     col_c;
  logic [ROM_AW-1:0] addr_c;
  logic              in_box_q, in_box_d;
  logic              hidden;

  // Sprite-relative coordinates; bit 10 is the borrow of the subtraction.
  always_comb begin
    rx_c     = {1'b0, DrawX} - {1'b0, boss_x};
    ry_c     = {1'b0, DrawY} - {1'b0, boss_y};
    in_box_c = !rx_c[10] && !ry_c[10] &&
               (rx_c < 11'(SPR_W)) && (ry_c < 11'(SPR_H));
`ifdef BOSS_HFLIP_EN
    col_c    = flip ? (XW'(SPR_W - 1) - rx_c[XW-1:0]) : rx_c[XW-1:0];
`else
    col_c    = rx_c[XW-1:0];
`endif
    addr_c   = ROM_AW'({ry_c[YW-1:0], col_c});
  end

  // Stage 1 address, ROM-latency match, stage 3 colour/visibility.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      in_box_q <= 1'b0;
      in_box_d <= 1'b0;
      index    <= 4'h0;
      boss_on  <= 1'b0;
    end else begin
      if (in_box_c) begin
        rom_addr <= addr_c;
      end
      in_box_q <= in_box_c;
      in_box_d <= in_box_q;
      index    <= in_box_d ? rom_data : 4'h0;
      boss_on  <= in_box_d && (rom_data != TRANSP_IDX) && !hidden;
    end
  end

  boss_flash_fsm #(
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_flash (
    .Clk         (Clk),
    .Reset       (Reset),
    .hit         (hit),
    .frame_start (frame_start),
    .hidden      (hidden),
    .flashing    (flashing)
  );

endmodule

// File: tb/tb_boss_sprite_fetch.sv
// Self-checking bench for boss_sprite_fetch: directed boundary cases plus
// randomized pixels/pulses compared against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_boss_sprite_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] drawx, drawy, boss_x, boss_y;
  logic       frame_start, hit, flip;
  logic [11:0] rom_addr;
  logic [3:0] rom_data, index;
  logic       boss_on, flashing;
  logic [3:0] rom [4096];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_addr;
  int         m_cnt;
  bit         m_hidden;
  bit         pix_in [2];
  int         pix_val [2];
  int         e_index;
  bit         e_on;

  always #5 clk = ~clk;

  boss_sprite_fetch dut (
    .Clk         (clk),
    .Reset       (reset),
    .DrawX       (drawx),
    .DrawY       (drawy),
    .frame_start (frame_start),
    .boss_x      (boss_x),
    .boss_y      (boss_y),
    .hit         (hit),
`ifdef BOSS_HFLIP_EN
    .flip        (flip),
`endif
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .index       (index),
    .boss_on     (boss_on),
    .flashing    (flashing)
  );

  // Synchronous sprite ROM, one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Reference model: box/address per pixel, 3-edge latency, frame-counted flash.
  always @(posedge clk) begin
    int dx, dy, col, a, v;
    bit inb;
    if (reset) begin
      m_addr   = 0;
      m_cnt    = 0;
      m_hidden = 0;
      pix_in[0] = 0; pix_in[1] = 0;
      pix_val[0] = 0; pix_val[1] = 0;
      e_index  = 0;
      e_on     = 0;
    end else begin
      e_index = pix_in[1] ? pix_val[1] : 0;
      e_on    = pix_in[1] && (pix_val[1] != 0) && !m_hidden;
      pix_in[1]  = pix_in[0];
      pix_val[1] = pix_val[0];
      dx  = int'(drawx) - int'(boss_x);
      dy  = int'(drawy) - int'(boss_y);
      inb = (dx >= 0) && (dx < 64) && (dy >= 0) && (dy < 64);
      col = flip ? (63 - dx) : dx;
      a   = dy * 64 + col;
      v   = 0;
      if (inb) begin
        m_addr = a;
        v      = int'(rom[a]);
      end
      pix_in[0]  = inb;
      pix_val[0] = v;
      if (hit) m_cnt = 16;
      else if (frame_start && m_cnt > 0) m_cnt = m_cnt - 1;
      if (frame_start) m_hidden = (m_cnt > 0) && (((m_cnt / 2) % 2) == 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("index", 32'(index), 32'(e_index));
    check("boss_on", 32'(boss_on), 32'(e_on));
    check("flashing", 32'(flashing), 32'(m_cnt > 0));
  endtask

  task automatic set_px(input int x, input int y);
    drawx = 10'(x);
    drawy = 10'(y);
  endtask

  task automatic pulse(input logic h, input logic f);
    hit = h; frame_start = f;
    cyc();
    hit = 1'b0; frame_start = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 4'(i);
    reset = 1'b1; frame_start = 1'b0; hit = 1'b0; flip = 1'b0;
    boss_x = 10'd100; boss_y = 10'd50;
    set_px(0, 0);
    cyc(); cyc();
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_index", 32'(index), 0);
    check("rst_flashing", 32'(flashing), 0);
    reset = 1'b0;

    // Box edges and address math
    set_px(100, 50); cyc();
    check("addr_origin", 32'(rom_addr), 0);
    set_px(0, 0); cyc(); cyc();
    check("idx_origin", 32'(index), 0);
    check("on_origin", 32'(boss_on), 0);
    set_px(101, 50); cyc(); set_px(0, 0); cyc(); cyc();
    check("idx_101", 32'(index), 1);
    check("on_101", 32'(boss_on), 1);
    set_px(164, 50); cyc(); set_px(0, 0); cyc(); cyc();
    check("on_164", 32'(boss_on), 0);
    set_px(99, 50); cyc(); set_px(0, 0); cyc(); cyc();
    check("on_99", 32'(boss_on), 0);
    set_px(163, 113); cyc();
    check("addr_corner", 32'(rom_addr), 4095);
`ifdef BOSS_HFLIP_EN
    flip = 1'b1;
    set_px(100, 50); cyc();
    check("addr_mirror", 32'(rom_addr), 63);
    flip = 1'b0;
`endif

    // Flash: hit then 16 frames, pixel held on an opaque texel
    set_px(101, 50);
    pulse(1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      pulse(1'b0, 1'b1);
      if (i == 15) check("flash_15", 32'(flashing), 1);
      if (i == 16) check("flash_16", 32'(flashing), 0);
    end

    // Retrigger at fcnt = 3
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 13; i++) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      pulse(1'b0, 1'b1);
      if (i == 15) check("retrig_15", 32'(flashing), 1);
      if (i == 16) check("retrig_16", 32'(flashing), 0);
    end

    // Coincident hit and frame_start reload to the full count
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      pulse(1'b0, 1'b1);
      if (i == 15) check("simul_15", 32'(flashing), 1);
      if (i == 16) check("simul_16", 32'(flashing), 0);
    end

    // Reset at fcnt = 8 with an opaque pixel in flight
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) pulse(1'b0, 1'b1);
    reset = 1'b1;
    cyc();
    check("rst_mid_flash", 32'(flashing), 0);
    check("rst_mid_on", 32'(boss_on), 0);
    check("rst_mid_index", 32'(index), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc();

    // Randomized pixels, positions, pulses and rare resets
    for (int i = 0; i < 4000; i++) begin
      int x, y;
      for (int j = 0; j < 4096; j++) if (i == 0) rom[j] = rom[j];
      if ($urandom_range(0, 199) == 0) begin
        boss_x = 10'($urandom_range(0, 639));
        boss_y = 10'($urandom_range(0, 479));
      end
      x = int'(boss_x) + int'($urandom_range(0, 80)) - 8;
      y = int'(boss_y) + int'($urandom_range(0, 80)) - 8;
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      set_px(x, y);
      hit         = ($urandom_range(0, 59) == 0);
      frame_start = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 499) == 0);
`ifdef BOSS_HFLIP_EN
      flip        = 1'($urandom_range(0, 1));
`endif
      cyc();
    end
    reset = 1'b0; hit = 1'b0; frame_start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
